// File: rtl/pcode_dispatcher.sv
// rtl/pcode_dispatcher.sv - turns an encoded priority winner into a held grant with ack/timeout release
// Upstream request clearing is driven by clr; svc_count counts ack-completed services.
module pcode_dispatcher #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] pcode,
  input  logic       ack,
  output logic [3:0] grant,
  output logic [1:0] chan,
  output logic       busy,
  output logic [3:0] clr,
  output logic       done,
  output logic       tmo,
  output logic       err,
  output logic [7:0] svc_count
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       chan_q, chan_d;
  logic [3:0]       clr_q, clr_d;
  logic             done_q, done_d;
  logic             tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [7:0]       svc_q, svc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       req_idx;

  // pcode 1..4 maps to channel 0..3; the 2-bit wrap handles pcode 4 -> 3
  assign req_idx = pcode[1:0] - 2'd1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    svc_d   = svc_q;
    clr_d   = 4'b0000;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pcode >= 3'd1 && pcode <= 3'd4) begin
          state_d = GRANT;
          grant_d = 4'b0001 << req_idx;
          chan_d  = req_idx;
          cnt_d   = '0;
        end else if (pcode >= 3'd5) begin
          err_d = 1'b1;
        end
      end
      GRANT: begin
        // ack takes precedence over a timeout landing on the same edge
        if (ack) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          clr_d   = 4'b0001 << chan_q;
          done_d  = 1'b1;
          svc_d   = svc_q + 8'd1;
        end else if (cnt_q == WAIT_MAX) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          clr_d   = 4'b0001 << chan_q;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      chan_q  <= 2'd0;
      cnt_q   <= '0;
      svc_q   <= 8'd0;
      clr_q   <= 4'b0000;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      svc_q   <= svc_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign grant     = grant_q;
  assign chan      = chan_q;
  assign busy      = (state_q != IDLE);
  assign clr       = clr_q;
  assign done      = done_q;
  assign tmo       = tmo_q;
  assign err       = err_q;
  assign svc_count = svc_q;

endmodule

// File: tb/tb_pcode_dispatcher.sv
// tb/tb_pcode_dispatcher.sv - directed bench for pcode_dispatcher
module tb_pcode_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] pcode;
  logic       ack;
  logic [3:0] grant;
  logic [1:0] chan;
  logic       busy;
  logic [3:0] clr;
  logic       done;
  logic       tmo;
  logic       err;
  logic [7:0] svc_count;

  int checks = 0;
  int failures = 0;

  pcode_dispatcher #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pcode(pcode), .ack(ack),
    .grant(grant), .chan(chan), .busy(busy), .clr(clr),
    .done(done), .tmo(tmo), .err(err), .svc_count(svc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // one ack-completed service: grant edge, ack edge, release edge
  task automatic service(input logic [2:0] pc);
    pcode = pc;
    cyc();
    pcode = 3'd0;
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    cyc();
  endtask

  initial begin
    rst_n = 1'b0;
    pcode = 3'd0;
    ack   = 1'b0;
    cyc();
    cyc();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_chan", 32'(chan), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_svc", 32'(svc_count), 32'h0);
    chk("rst_pulses", {clr, done, tmo, err}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // ack sampled on the third edge after the grant edge
    pcode = 3'b011;
    cyc();
    chk("t1_grant", 32'(grant), 32'h4);
    chk("t1_chan", 32'(chan), 32'h2);
    chk("t1_busy", 32'(busy), 32'h1);
    pcode = 3'd0;
    cyc();
    chk("t1_hold1", 32'(grant), 32'h4);
    cyc();
    chk("t1_hold2", 32'(grant), 32'h4);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_clr", 32'(clr), 32'h4);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_svc", 32'(svc_count), 32'h1);
    chk("t1_rel_busy", 32'(busy), 32'h1);
    cyc();
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_pulses", {clr, done, tmo}, 32'h0);

    // no ack: timeout after 15 grant cycles
    pcode = 3'b001;
    cyc();
    chk("t2_grant", 32'(grant), 32'h1);
    pcode = 3'd0;
    for (int i = 0; i < 14; i++) cyc();
    chk("t2_grant_last", 32'(grant), 32'h1);
    chk("t2_no_tmo_yet", 32'(tmo), 32'h0);
    cyc();
    chk("t2_grant_off", 32'(grant), 32'h0);
    chk("t2_tmo", 32'(tmo), 32'h1);
    chk("t2_clr", 32'(clr), 32'h1);
    chk("t2_done", 32'(done), 32'h0);
    chk("t2_svc", 32'(svc_count), 32'h1);
    cyc();
    chk("t2_tmo_off", 32'(tmo), 32'h0);
    chk("t2_busy_off", 32'(busy), 32'h0);

    // higher-priority arrival during GRANT does not pre-empt
    pcode = 3'b010;
    cyc();
    chk("t3_grant", 32'(grant), 32'h2);
    chk("t3_chan", 32'(chan), 32'h1);
    pcode = 3'b100;
    cyc();
    chk("t3_no_preempt", 32'(grant), 32'h2);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_clr", 32'(clr), 32'h2);
    cyc();
    chk("t3_release_gap", 32'(grant), 32'h0);
    cyc();
    chk("t3_next_grant", 32'(grant), 32'h8);
    chk("t3_next_chan", 32'(chan), 32'h3);
    pcode = 3'd0;
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t3_svc", 32'(svc_count), 32'h3);
    chk("t3_clr2", 32'(clr), 32'h8);
    cyc();

    // illegal pcode in IDLE, and ack in IDLE
    pcode = 3'b110;
    cyc();
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_grant", 32'(grant), 32'h0);
    chk("t4_busy", 32'(busy), 32'h0);
    pcode = 3'd0;
    cyc();
    chk("t4_err_off", 32'(err), 32'h0);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t4_ack_idle", {grant, clr, done, tmo, err, busy}, 32'h0);
    chk("t4_ack_svc", 32'(svc_count), 32'h3);

    // ack on the same edge the wait counter hits TIMEOUT-1
    pcode = 3'b001;
    cyc();
    pcode = 3'd0;
    for (int i = 0; i < 14; i++) cyc();
    chk("t5_still_grant", 32'(grant), 32'h1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_tmo", 32'(tmo), 32'h0);
    chk("t5_svc", 32'(svc_count), 32'h4);
    cyc();

    // service counter wrap
    for (int i = 0; i < 251; i++) service(3'b010);
    chk("t5_svc_255", 32'(svc_count), 32'hff);
    service(3'b011);
    chk("t5_svc_wrap", 32'(svc_count), 32'h0);
    for (int i = 0; i < 4; i++) service(3'b100);
    chk("t5_svc_after", 32'(svc_count), 32'h4);

    // asynchronous reset mid-GRANT
    pcode = 3'b100;
    cyc();
    chk("t6_grant", 32'(grant), 32'h8);
    pcode = 3'd0;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_busy", 32'(busy), 32'h0);
    chk("t6_async_pulses", {clr, done, tmo, err}, 32'h0);
    chk("t6_async_svc", 32'(svc_count), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t6_post_idle", {grant, clr, busy}, 32'h0);
    pcode = 3'b100;
    cyc();
    chk("t6_regrant", 32'(grant), 32'h8);
    chk("t6_regrant_chan", 32'(chan), 32'h3);
    pcode = 3'd0;
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_svc", 32'(svc_count), 32'h1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcode_dispatcher.md
# pcode_dispatcher

Downstream consumer of the 4-input priority encoder's 3-bit `pcode`. It turns the encoded winner into a held one-hot grant and waits for the served channel's acknowledge, bounded by a timeout. It then pulses a per-channel clear back to the upstream request register so the next-priority request can surface. A wrap-around service counter tracks completed services for debug.

## Interface

- `TIMEOUT`, default 15: grant cycles allowed without ack before forced release; legal range 1..2^CNT_W.
- `CNT_W`, default 4: width of the internal wait counter; must hold TIMEOUT-1.
- `clk`  input  1: single clock; all state changes on rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `pcode`  input  3: encoder output.
  - 3'b000: no request.
  - 3'b001..3'b100: channel 0..3, i.e. channel = pcode-1.
  - 3'b101..3'b111: illegal.
- `ack`  input  1: served channel finished; level, sampled only in GRANT.
- `grant`  output  4: one-hot grant, registered, held until release.
- `chan`  output  2: index of channel latched at grant start; holds its value after release.
- `busy`  output  1: high in GRANT and RELEASE.
- `clr`  output  4: one-cycle one-hot pulse clearing the served request upstream.
- `done`  output  1: one-cycle pulse, service completed by ack.
- `tmo`  output  1: one-cycle pulse, service aborted by timeout.
- `err`  output  1: one-cycle pulse, illegal pcode sampled in IDLE.
- `svc_count`  output  8: count of `done` pulses, wraps 255 -> 0.

## Operation

- All outputs are registered. There is no combinational path from `pcode` or `ack` to any output.
- The FSM has three states: IDLE, GRANT and RELEASE.
- IDLE:
  - pcode in 1..4: go to GRANT. Set grant[pcode-1]=1, set chan=pcode-1, clear the wait counter.
  - pcode in 5..7: stay in IDLE and pulse `err`.
  - pcode 0: stay in IDLE.
- GRANT:
  - `pcode` is ignored; a higher-priority arrival does not pre-empt the current grant.
  - ack=1: go to RELEASE. Set grant=0, pulse clr[chan] and `done`, and increment svc_count.
  - Otherwise, if the wait counter equals TIMEOUT-1: go to RELEASE. Set grant=0 and pulse clr[chan] and `tmo`. The request is dropped.
  - Otherwise: increment the wait counter.
  - ack and timeout on the same edge: ack wins. `done` pulses and `tmo` does not.
- RELEASE:
  - Lasts one cycle and then returns to IDLE unconditionally.
  - This gives the upstream request register and encoder one cycle to reflect the clear before the next pcode sample.
- `ack` outside GRANT is ignored with no side effect.
- Reset (asynchronous, rst_n=0):
  - State returns to IDLE.
  - grant, chan, clr, done, tmo, err, svc_count and the wait counter all go to 0, and busy goes to 0.
  - Reset asserted mid-GRANT drops grant immediately. No clr, done or tmo is produced.

## Timing

- Grant latency: pcode sampled at edge E0 puts grant high from E0 onward (1 cycle after pcode is presented).
- Hold: grant stays high through edge Ek, where ack=1 is sampled. It goes low after Ek, with clr and done high for the cycle after Ek.
- Minimum grant width is 1 cycle (ack already high at E0+1). Maximum is TIMEOUT cycles.
- Back-to-back services: earliest next pcode sample is edge Ek+2. grant is low for exactly 2 cycles between services.
- clr, done, tmo and err are each exactly one cycle wide and never asserted in consecutive cycles by the same event.
- busy rises with grant and falls one cycle after grant falls.

## Test plan

- Reset, then pcode=3'b011 with ack rising 3 cycles after grant: grant=4'b0100 and chan=2 one cycle after the sample. grant is held 3 cycles, then clr=4'b0100 and done=1 for one cycle, and svc_count=1. IDLE resumes 2 cycles after ack.
- pcode=3'b001 with ack never asserted, TIMEOUT=15: grant=4'b0001 for exactly 15 cycles, then tmo=1 and clr=4'b0001 for one cycle. done=0 and svc_count is unchanged.
- pcode changes 3'b010 -> 3'b100 during GRANT: grant stays 4'b0010 until ack. The new pcode is taken only at the first IDLE sample, giving grant=4'b1000.
- pcode=3'b110 in IDLE: err=1 for one cycle, grant stays 0, no state change. ack pulses while in IDLE cause no output change.
- ack asserted on the same edge the counter reaches TIMEOUT-1: done=1, tmo=0, svc_count increments. Then run 256 completed services and check svc_count wraps from 255 to 0.
- rst_n driven low mid-GRANT (grant=4'b1000): grant, busy and all pulses go to 0 asynchronously with no clr. After release of reset, the block is in IDLE and pcode=3'b100 is granted normally.
